ddr_burst_mem: RTL and testbench
================================

Name: ddr_burst_mem

Overview:
- Parametrised successor to the team's dual-edge DDR memory. Single clock domain; each rising edge moves two words, lane 0 (even word) and lane 1 (odd word), over a 2*DATA_W bus.
- Accesses are BURST_LEN-beat bursts issued through a valid/ready command handshake.
- Adds per-lane write masks, address wrap-around and a registered read-valid strobe.
- Sits between a command source (test driver or controller) and downstream data consumers.

Parameters:
- DATA_W, 8, bits per word.
- ADDR_W, 3, word address width. DEPTH = 2**ADDR_W words, ADDR_W >= 2.
- BURST_LEN, 4, beats per burst (1..DEPTH/2). Each beat is 2 words.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state and the whole memory
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_wr  in  1  1 = write burst, 0 = read burst
- cmd_addr  in  ADDR_W  start word address; bit 0 ignored, so bursts are pair-aligned
- wdata  in  2*DATA_W  [DATA_W-1:0] goes to the even word, upper half to the odd word
- wmask  in  2  bit0 enables lane 0, bit1 enables lane 1
- wdata_valid  in  1  write beat present
- rdata  out  2*DATA_W  read beat, same lane order as wdata
- rdata_valid  out  1  rdata holds a valid beat this cycle
- busy  out  1  burst in progress; equal to ~cmd_ready

Behaviour:
- Reset, asynchronous:
  - FSM goes to IDLE. Beat counter and base address are cleared.
  - Every memory word, indices 0..DEPTH-1 with none skipped, becomes 0.
  - rdata=0, rdata_valid=0, cmd_ready=1, busy=0.
  - Reset asserted mid-burst aborts the burst immediately. No partial-beat commit after the reset edge.
- FSM states: IDLE, WRITE, READ.
- IDLE:
  - cmd_ready=1.
  - On a rising edge with cmd_valid=1: latch base={cmd_addr[ADDR_W-1:1],1'b0}, clear the beat counter, go to WRITE if cmd_wr=1, else READ.
  - wdata_valid in IDLE is ignored.
- Beat k address: even word = (base + 2k) mod DEPTH, odd word = even + 1. Wrap-around is natural modulo DEPTH.
- WRITE:
  - On each edge with wdata_valid=1, write lane 0 if wmask[0]=1 and lane 1 if wmask[1]=1, then increment k.
  - wdata_valid=0 stalls with no write and no count; a stall has no length limit.
  - After the beat with k=BURST_LEN-1 is accepted, go to IDLE. cmd_ready is high in the next cycle.
  - wmask=00 still consumes a beat.
- READ:
  - No stalls. One beat per cycle for BURST_LEN consecutive edges following command acceptance.
  - Each of those edges registers memory into rdata and sets rdata_valid=1.
  - Latency: command accepted at edge N, beats are valid after edges N+1..N+BURST_LEN.
  - At edge N+BURST_LEN the FSM returns to IDLE. At the next edge rdata_valid returns to 0 and rdata holds its last value.
- cmd_valid while busy is ignored and not queued; the source must hold it until cmd_ready.
- Read data reflects all writes completed at earlier edges. No read/write overlap is possible.
- Widths: the beat counter is clog2(BURST_LEN)+1 bits; address arithmetic is ADDR_W bits and truncates.

Test Plan (DATA_W=8, ADDR_W=3, BURST_LEN=2):
1. Release reset, then issue a read at addr 0 -> rdata_valid high exactly 2 cycles starting 1 edge after acceptance, rdata 0x0000 both beats; cmd_ready low for 2 cycles.
2. Write at addr 2, beats 0xBBAA and 0xDDCC, wmask=11, then read at addr 3 (bit 0 ignored, so it acts as 2) -> rdata 0xBBAA, then 0xDDCC.
3. Wrap: write at addr 6, beats 0x2211 and 0x4433; read at addr 6 -> 0x2211, 0x4433; read at addr 0 -> 0x4433, then word pair 2/3 (0xBBAA).
4. Mask: with the state from test 2, write at addr 2, beat 1 = 0xFFEE with wmask=01, beat 2 with wmask=00 -> read at addr 2 returns 0xBBEE, 0xDDCC.
5. Stall: write burst with wdata_valid low for 3 cycles between beats, and cmd_valid pulsed during the stall -> busy stays 1, the extra command is ignored, both beats land correctly, cmd_ready rises only after the second beat.
6. Assert reset asynchronously (between edges) during the first read beat -> rdata_valid and rdata go to 0 without a clock; after release, cmd_ready=1 and a read at addr 2 returns 0x0000, 0x0000.

Source files
------------

// File: rtl/ddr_burst_mem.sv
// ddr_burst_mem: two-lane (even/odd word) burst memory with a valid/ready
// command handshake, per-lane write masks, address wrap-around and a
// registered read-valid strobe. Each rising edge moves one two-word beat.
module ddr_burst_mem #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 3,
    parameter int BURST_LEN = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_wr,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [2*DATA_W-1:0] wdata,
    input  logic [1:0]          wmask,
    input  logic                wdata_valid,
    output logic [2*DATA_W-1:0] rdata,
    output logic                rdata_valid,
    output logic                busy
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = $clog2(BURST_LEN) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_n;
    logic [CNT_W-1:0]    beat_r;
    logic [ADDR_W-1:0]   base_r;
    logic [DATA_W-1:0]   mem_r [DEPTH];
    logic [ADDR_W-1:0]   addr_even_s;
    logic [ADDR_W-1:0]   addr_odd_s;
    logic                last_beat_s;
    logic                accept_s;
    logic                wr_beat_s;
    logic                unused_addr_lsb_s;

    // Bit 0 of the command address is deliberately dropped (pair alignment).
    assign unused_addr_lsb_s = cmd_addr[0];

    // Beat address: base + 2k truncated to ADDR_W bits gives natural wrap.
    assign addr_even_s = base_r + ADDR_W'({beat_r, 1'b0});
    assign addr_odd_s  = {addr_even_s[ADDR_W-1:1], 1'b1};
    assign last_beat_s = (beat_r == CNT_W'(BURST_LEN - 1));
    assign accept_s    = (state_r == IDLE) && cmd_valid;
    assign wr_beat_s   = (state_r == WRITE) && wdata_valid;

    // Next-state decode for the IDLE/WRITE/READ burst sequencer.
    always_comb begin
        state_n = state_r;
        case (state_r)
            IDLE: begin
                if (cmd_valid) begin
                    state_n = cmd_wr ? WRITE : READ;
                end else begin
                    state_n = IDLE;
                end
            end
            WRITE: begin
                if (wdata_valid && last_beat_s) begin
                    state_n = IDLE;
                end else begin
                    state_n = WRITE;
                end
            end
            READ: begin
                if (last_beat_s) begin
                    state_n = IDLE;
                end else begin
                    state_n = READ;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State register plus registered handshake outputs derived from next state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r   <= IDLE;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
        end else begin
            state_r   <= state_n;
            cmd_ready <= (state_n == IDLE);
            busy      <= (state_n != IDLE);
        end
    end

    // Base address latch on acceptance; beat counter advances per moved beat.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            base_r <= {ADDR_W{1'b0}};
            beat_r <= {CNT_W{1'b0}};
        end else if (accept_s) begin
            base_r <= {cmd_addr[ADDR_W-1:1], 1'b0};
            beat_r <= {CNT_W{1'b0}};
        end else if (wr_beat_s || (state_r == READ)) begin
            beat_r <= beat_r + CNT_W'(1);
        end
    end

    // Storage array: cleared in full on reset, masked per-lane writes otherwise.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
        end else if (wr_beat_s) begin
            if (wmask[0]) begin
                mem_r[addr_even_s] <= wdata[DATA_W-1:0];
            end
            if (wmask[1]) begin
                mem_r[addr_odd_s] <= wdata[2*DATA_W-1:DATA_W];
            end
        end
    end

    // Read beat register: valid for each READ-state edge, data holds afterwards.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rdata       <= {(2*DATA_W){1'b0}};
            rdata_valid <= 1'b0;
        end else if (state_r == READ) begin
            rdata       <= {mem_r[addr_odd_s], mem_r[addr_even_s]};
            rdata_valid <= 1'b1;
        end else begin
            rdata_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ddr_burst_mem.sv
// Self-checking bench for ddr_burst_mem (DATA_W=8, ADDR_W=3, BURST_LEN=2).
// Expected read data comes from a plain word-array model of the memory.
module tb_ddr_burst_mem;

    localparam int DW    = 8;
    localparam int AW    = 3;
    localparam int BL    = 2;
    localparam int DEPTH = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_wr = 1'b0;
    logic [AW-1:0] cmd_addr = 3'd0;
    logic [15:0]   wdata = 16'h0000;
    logic [1:0]    wmask = 2'b00;
    logic          wdata_valid = 1'b0;
    logic [15:0]   rdata;
    logic          rdata_valid;
    logic          busy;

    int checks = 0;
    int failures = 0;

    logic [7:0]  ref_mem [DEPTH];
    logic [15:0] beat_data [BL];
    logic [1:0]  beat_mask [BL];

    ddr_burst_mem #(.DATA_W(DW), .ADDR_W(AW), .BURST_LEN(BL)) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .wdata(wdata), .wmask(wmask),
        .wdata_valid(wdata_valid), .rdata(rdata), .rdata_valid(rdata_valid),
        .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
    endtask

    function automatic logic [15:0] model_pair(input int base, input int k);
        int e;
        e = (base + 2 * k) % DEPTH;
        return {ref_mem[e + 1], ref_mem[e]};
    endfunction

    // Write burst from beat_data/beat_mask; optional stall cycles before each
    // beat after the first, with an ignored read command pulsed in the stall.
    task automatic do_write(input int addr, input int stall, input bit poke);
        int base;
        int e;
        base = (addr / 2) * 2;
        @(negedge clock);
        chk("wr_ready_before", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = addr[AW-1:0];
        @(negedge clock);
        cmd_valid = 1'b0;
        chk("wr_busy_after_accept", {31'd0, busy}, 32'd1);
        for (int b = 0; b < BL; b++) begin
            if (b > 0) begin
                for (int s = 0; s < stall; s++) begin
                    wdata_valid = 1'b0;
                    cmd_valid = poke; cmd_wr = 1'b0; cmd_addr = 3'd4;
                    wdata = 16'hDEAD;
                    @(negedge clock);
                    chk("wr_stall_busy", {31'd0, busy}, 32'd1);
                    chk("wr_stall_ready", {31'd0, cmd_ready}, 32'd0);
                end
                cmd_valid = 1'b0;
            end
            wdata = beat_data[b]; wmask = beat_mask[b]; wdata_valid = 1'b1;
            @(posedge clock);
            e = (base + 2 * b) % DEPTH;
            if (beat_mask[b][0]) ref_mem[e] = beat_data[b][7:0];
            if (beat_mask[b][1]) ref_mem[e + 1] = beat_data[b][15:8];
            @(negedge clock);
            wdata_valid = 1'b0;
            chk("wr_ready_per_beat", {31'd0, cmd_ready}, (b == BL - 1) ? 32'd1 : 32'd0);
        end
        chk("wr_no_rvalid", {31'd0, rdata_valid}, 32'd0);
    endtask

    // Read burst: beats valid after edges N+1..N+BL, then valid drops, data holds.
    task automatic do_read(input int addr);
        int base;
        logic [15:0] last;
        base = (addr / 2) * 2;
        @(negedge clock);
        chk("rd_ready_before", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = addr[AW-1:0];
        @(negedge clock);
        cmd_valid = 1'b0;
        chk("rd_valid_at_accept", {31'd0, rdata_valid}, 32'd0);
        chk("rd_busy_after_accept", {31'd0, busy}, 32'd1);
        for (int b = 0; b < BL; b++) begin
            @(negedge clock);
            last = model_pair(base, b);
            chk("rd_valid_beat", {31'd0, rdata_valid}, 32'd1);
            chk("rd_data_beat", {16'd0, rdata}, {16'd0, last});
            chk("rd_ready_in_beat", {31'd0, cmd_ready}, (b == BL - 1) ? 32'd1 : 32'd0);
        end
        @(negedge clock);
        chk("rd_valid_drop", {31'd0, rdata_valid}, 32'd0);
        chk("rd_data_hold", {16'd0, rdata}, {16'd0, last});
    endtask

    initial begin
        clear_model();
        // Reset state while reset is asserted
        @(negedge clock);
        @(negedge clock);
        chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rvalid", {31'd0, rdata_valid}, 32'd0);
        chk("rst_rdata", {16'd0, rdata}, 32'd0);
        reset = 1'b0;

        // 1. Read of the cleared memory
        do_read(0);
        // 2. Full write at 2, read back through odd address 3
        beat_data[0] = 16'hBBAA; beat_data[1] = 16'hDDCC;
        beat_mask[0] = 2'b11; beat_mask[1] = 2'b11;
        do_write(2, 0, 1'b0);
        do_read(3);
        chk("t2_const", {24'd0, ref_mem[2]}, 32'h000000AA);
        // 3. Wrap-around
        beat_data[0] = 16'h2211; beat_data[1] = 16'h4433;
        do_write(6, 0, 1'b0);
        do_read(6);
        do_read(0);
        // 4. Lane masks, including an all-off mask that still consumes a beat
        beat_data[0] = 16'hFFEE; beat_data[1] = 16'h9988;
        beat_mask[0] = 2'b01; beat_mask[1] = 2'b00;
        do_write(2, 0, 1'b0);
        do_read(2);
        chk("t4_const", {16'd0, ref_mem[3], ref_mem[2]}, 32'h0000BBEE);
        // 5. Stalled write with an ignored command during the stall
        beat_data[0] = 16'h5A5A; beat_data[1] = 16'hC3C3;
        beat_mask[0] = 2'b11; beat_mask[1] = 2'b11;
        do_write(4, 3, 1'b1);
        do_read(4);

        // Randomized mixed traffic
        for (int it = 0; it < 24; it++) begin
            if ($urandom_range(0, 1) == 1) begin
                for (int b = 0; b < BL; b++) begin
                    beat_data[b] = 16'($urandom);
                    beat_mask[b] = 2'($urandom_range(0, 3));
                end
                do_write(int'($urandom_range(0, 7)), int'($urandom_range(0, 2)),
                         1'($urandom_range(0, 1)));
            end else begin
                do_read(int'($urandom_range(0, 7)));
            end
        end

        // 6. Asynchronous reset during the first read beat
        @(negedge clock);
        cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 3'd2;
        @(negedge clock);
        cmd_valid = 1'b0;
        @(negedge clock);
        chk("t6_first_beat_valid", {31'd0, rdata_valid}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("t6_async_rvalid", {31'd0, rdata_valid}, 32'd0);
        chk("t6_async_rdata", {16'd0, rdata}, 32'd0);
        chk("t6_async_ready", {31'd0, cmd_ready}, 32'd1);
        chk("t6_async_busy", {31'd0, busy}, 32'd0);
        clear_model();
        @(negedge clock);
        reset = 1'b0;
        do_read(2);
        do_read(6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
